// File: rtl/homomorphic_multiply_core_pkg.sv
// homomorphic_multiply_core_pkg: shared default parameters and coefficient type
package homomorphic_multiply_core_pkg;
  localparam int DEF_PLAINTEXT_MODULUS  = 64;
  localparam int DEF_PLAINTEXT_WIDTH    = 6;
  localparam int DEF_CIPHERTEXT_MODULUS = 1024;
  localparam int DEF_CIPHERTEXT_WIDTH   = 10;
  localparam int DEF_DIMENSION          = 1;
  localparam int DEF_BIG_N              = 30;
  typedef logic [DEF_CIPHERTEXT_WIDTH-1:0] coeff_t;
endpackage

// File: rtl/homomorphic_multiply_core_mod_mult.sv
// mod_mult: W x W multiply reduced mod 2^W
module mod_mult #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);
  // A W-bit result context keeps exactly the low half of the full 2W-bit product
  assign p = a * b;
endmodule

// File: rtl/homomorphic_multiply_core.sv
// homomorphic_multiply_core: streaming polynomial product of two ciphertexts mod 2^W
module homomorphic_multiply_core
  import homomorphic_multiply_core_pkg::*;
#(
  parameter int PLAINTEXT_MODULUS  = DEF_PLAINTEXT_MODULUS,
  parameter int PLAINTEXT_WIDTH    = DEF_PLAINTEXT_WIDTH,
  parameter int CIPHERTEXT_MODULUS = DEF_CIPHERTEXT_MODULUS,
  parameter int CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH,
  parameter int DIMENSION          = DEF_DIMENSION,
  parameter int BIG_N              = DEF_BIG_N
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic signed [CIPHERTEXT_WIDTH-1:0] ciphertext_entry,
  input  logic        [DIMENSION:0]          row,
  input  logic                               ciphertext_select,
  input  logic                               en,
  output logic        [CIPHERTEXT_WIDTH-1:0] result_partial
);
  localparam int W = CIPHERTEXT_WIDTH;
  localparam int D = DIMENSION;
  if (CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH) || PLAINTEXT_MODULUS != (1 << PLAINTEXT_WIDTH) || BIG_N < 0) begin : g_bad_params
    $error("homomorphic_multiply_core: inconsistent moduli/widths");
  end
  logic [W-1:0] a_q [D+1];
  logic [W-1:0] a_d [D+1];
  logic [W-1:0] b_q [D+1];
  logic [W-1:0] b_d [D+1];
  logic [W-1:0] acc_q [2*D+1];
  logic [W-1:0] acc_d [2*D+1];
  logic [W-1:0] res_q, res_d;
  logic [W-1:0] prod [D+1];
  logic [W-1:0] entry;
  int r;
  assign entry = ciphertext_entry;
  assign r = int'(row);
  assign result_partial = res_q;
  // Each stored a_i is multiplied by the incoming b_j so the row completes in one cycle
  for (genvar i = 0; i <= D; i++) begin : g_mult
    mod_mult #(.W(W)) u_mult (.a(a_q[i]), .b(entry), .p(prod[i]));
  end
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    res_d = res_q;
    if (en) begin
      if (!ciphertext_select && r <= D) begin
        a_d[r] = entry;
        if (r == 0)
          for (int k = 0; k <= 2*D; k++) acc_d[k] = '0;
      end else if (ciphertext_select && r <= D) begin
        b_d[r] = entry;
        res_d = acc_q[r] + prod[0];
        for (int i = 1; i <= D; i++) acc_d[i+r] = acc_q[i+r] + prod[i];
      end else begin
        res_d = (!ciphertext_select && r <= 2*D) ? acc_q[r] : '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      acc_q <= '{default: '0};
      res_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_homomorphic_multiply_core.sv
// tb_homomorphic_multiply_core: scoreboard bench with directed product vectors
module tb_homomorphic_multiply_core;
  import homomorphic_multiply_core_pkg::*;
  typedef struct { string tag; coeff_t v; } exp_t;
  logic clk = 0;
  logic rst_n = 1;
  logic signed [9:0] ciphertext_entry = '0;
  logic [1:0] row = '0;
  logic ciphertext_select = 0;
  logic en = 0;
  logic [9:0] result_partial;
  logic chk = 0;
  logic chk_q = 0;
  exp_t exp_q [$];
  int checks = 0;
  int failures = 0;
  homomorphic_multiply_core dut (
    .clk(clk), .rst_n(rst_n), .ciphertext_entry(ciphertext_entry), .row(row),
    .ciphertext_select(ciphertext_select), .en(en), .result_partial(result_partial)
  );
  always #5 clk = ~clk;
  always @(posedge clk) chk_q <= chk;
  always @(negedge clk) begin
    if (chk_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow got=%0d want=<none>", result_partial);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (result_partial !== e.v) begin
          failures++;
          $display("FAIL %s got=%0d want=%0d", e.tag, result_partial, e.v);
        end
      end
    end
  end
  task automatic step(input logic e, input logic s, input logic [1:0] rw, input logic [9:0] d, input string tag, input logic [9:0] x);
    exp_t item;
    @(negedge clk);
    en = e; ciphertext_select = s; row = rw; ciphertext_entry = d; chk = 1;
    item.tag = tag; item.v = x;
    exp_q.push_back(item);
  endtask
  task automatic load_a(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] hold);
    step(1, 0, 0, a0, "a_load_hold0", hold);
    step(1, 0, 1, a1, "a_load_hold1", hold);
  endtask
  task automatic mul(input logic [9:0] b0, input logic [9:0] b1, input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
    step(1, 1, 0, b0, "c0", c0);
    step(1, 1, 1, b1, "c1", c1);
    step(1, 0, 2, 10'd0, "c2_drain", c2);
  endtask
  task automatic direct(input string tag, input logic [9:0] x);
    checks++;
    if (result_partial !== x) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, result_partial, x);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    direct("reset_state", 10'd0);
    rst_n = 0;
    load_a(10'd11, 10'd948, 10'd0);
    mul(10'd805, 10'd374, 10'd663, 10'd278, 10'd248);
    step(1, 0, 2, 10'd0, "redrain", 10'd248);
    step(1, 0, 3, 10'd7, "row_oob", 10'd0);
    step(1, 0, 2, 10'd0, "acc_kept_oob", 10'd248);
    step(1, 1, 2, 10'd9, "b_row_oob", 10'd0);
    step(1, 0, 2, 10'd0, "acc_kept_boob", 10'd248);
    load_a(10'd1, 10'd1, 10'd248);
    mul(10'd1, 10'd1, 10'd1, 10'd2, 10'd1);
    load_a(10'd1023, 10'd0, 10'd1);
    mul(10'd1023, 10'd0, 10'd1, 10'd0, 10'd0);
    load_a(10'd11, 10'd948, 10'd0);
    step(1, 1, 0, 10'd805, "stall_c0", 10'd663);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 10'd5, "stall_hold", 10'd663);
    step(1, 1, 1, 10'd374, "stall_c1", 10'd278);
    step(1, 0, 2, 10'd0, "stall_c2", 10'd248);
    load_a(10'd11, 10'd948, 10'd248);
    step(1, 1, 0, 10'd805, "pre_reset_c0", 10'd663);
    @(negedge clk);
    en = 0; chk = 0;
    #2 rst_n = 1;
    #1 direct("async_reset", 10'd0);
    @(negedge clk);
    rst_n = 0;
    load_a(10'd11, 10'd948, 10'd0);
    mul(10'd805, 10'd374, 10'd663, 10'd278, 10'd248);
    @(negedge clk);
    en = 0; chk = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
